axis_to_axi4_writer: RTL and testbench

Stream-to-memory write master (S2MM DMA) that sits directly upstream of the AXI4 RAM. It accepts one AXI-Stream frame per `start` command, buffers the beats in an internal FIFO and writes them as INCR bursts to consecutive word addresses starting at `base_addr`. Completion and response errors are reported through `done`, `busy` and `error` to the peripheral control block.

---
 rtl/axis_to_axi4_writer_if.sv | 48 ++++
 rtl/axis_to_axi4_writer.sv | 168 ++++++++++++++++
 tb/tb_axis_to_axi4_writer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_to_axi4_writer_if.sv
// AXI4 bundle between the stream writer (master) and the AXI4 RAM (slave).
// The write channels carry the traffic. The writer ties the read channels off.
interface axi4_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arlen, arsize, arburst, arvalid, input arready,
    input rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arlen, arsize, arburst, arvalid, output arready,
    output rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axis_to_axi4_writer.sv
// S2MM write master: buffers one AXI-Stream frame per start and writes it as AXI4 INCR bursts.
// Define AXIS_WR_4K_SPLIT_EN to clamp bursts so they never cross a 4 KB boundary.
module axis_to_axi4_writer #(
  parameter int BURST_LEN   = 16,
  parameter int FIFO_DEPTH  = 32,
  parameter int AXI4_ADDR_W = 32,
  parameter int AXI4_DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [AXI4_ADDR_W-1:0] base_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [15:0]            beats_written,
  input  logic [AXI4_DATA_W-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  axi4_if.master                 axi
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {IDLE, FILL, ADDR, DATA, RESP, DONE} state_t;
  state_t state, state_next;

  logic [AXI4_DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          fifo_count;
  logic [AXI4_ADDR_W-1:0] addr;
  logic [8:0]             burst_len, len_calc, beat_cnt;
  logic [31:0]            limit, avail;
  logic                   last_accepted, burst_ready, last_written;
  logic                   push, pop, fifo_full, fifo_empty, start_ok;
  logic                   w_active, w_last_beat;
  logic                   unused_base_bits;

  assign unused_base_bits = ^base_addr[1:0];
  assign fifo_full     = fifo_count == CW'(FIFO_DEPTH);
  assign fifo_empty    = fifo_count == '0;
  assign busy          = state != IDLE;
  assign done          = state == DONE;
  assign start_ok      = (state == IDLE) && start;
  assign s_axis_tready = busy && !fifo_full && !last_accepted;
  assign push          = s_axis_tvalid && s_axis_tready;
  assign w_active      = (state == DATA) && !fifo_empty;
  assign w_last_beat   = beat_cnt == (burst_len - 9'd1);
  assign pop           = w_active && axi.wready;
  // Nothing is accepted after tlast, so an empty FIFO with tlast seen means the frame is fully written.
  assign last_written  = last_accepted && fifo_empty;

  always_comb begin
    limit = 32'(BURST_LEN);
`ifdef AXIS_WR_4K_SPLIT_EN
    if (32'(11'd1024 - {1'b0, addr[11:2]}) < limit) limit = 32'(11'd1024 - {1'b0, addr[11:2]});
`endif
    avail       = 32'(fifo_count);
    len_calc    = 9'((avail < limit) ? avail : limit);
    burst_ready = (avail >= limit) || (last_accepted && !fifo_empty);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    axi.awvalid = 1'b0;
    axi.awaddr  = '0;
    axi.awlen   = '0;
    axi.awsize  = '0;
    axi.awburst = '0;
    axi.wvalid  = 1'b0;
    axi.wdata   = '0;
    axi.wstrb   = '0;
    axi.wlast   = 1'b0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0;
    axi.araddr  = '0;
    axi.arlen   = '0;
    axi.arsize  = '0;
    axi.arburst = '0;
    axi.rready  = 1'b0;
    case (state)
      IDLE: if (start) state_next = FILL;
      FILL: if (burst_ready) state_next = ADDR;
      ADDR: begin
        axi.awvalid = 1'b1;
        axi.awaddr  = addr;
        axi.awlen   = 8'(burst_len - 9'd1);
        axi.awsize  = 3'b010;
        axi.awburst = 2'b01;
        if (axi.awready) state_next = DATA;
      end
      DATA: begin
        if (w_active) begin
          axi.wvalid = 1'b1;
          axi.wdata  = fifo_mem[rd_ptr];
          axi.wstrb  = '1;
          axi.wlast  = w_last_beat;
        end
        if (pop && w_last_beat) state_next = RESP;
      end
      RESP: begin
        axi.bready = 1'b1;
        if (axi.bvalid) state_next = last_written ? DONE : FILL;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= s_axis_tdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr          <= '0;
      burst_len     <= '0;
      beat_cnt      <= '0;
      last_accepted <= 1'b0;
      error         <= 1'b0;
      beats_written <= '0;
    end else begin
      if (start_ok) begin
        addr          <= {base_addr[AXI4_ADDR_W-1:2], 2'b00};
        error         <= 1'b0;
        beats_written <= '0;
        last_accepted <= 1'b0;
      end else if (push && s_axis_tlast) begin
        last_accepted <= 1'b1;
      end
      // Length is frozen when the burst is committed so AW stays stable while beats keep arriving.
      if (state == FILL && burst_ready) begin
        burst_len <= len_calc;
        beat_cnt  <= '0;
      end
      if (pop) begin
        beat_cnt <= beat_cnt + 9'd1;
        if (beats_written != 16'hFFFF) beats_written <= beats_written + 16'd1;
      end
      if (state == RESP && axi.bvalid) begin
        if (axi.bresp != 2'b00) error <= 1'b1;
        addr <= addr + (AXI4_ADDR_W'(burst_len) << 2);
      end
    end
  end
endmodule

// File: tb/tb_axis_to_axi4_writer.sv
// Self-checking bench for axis_to_axi4_writer: AXI4 RAM slave model plus a scoreboard of expected bursts and beats.
// Expected bursts for the 4 KB case follow AXIS_WR_4K_SPLIT_EN.
module tb_axis_to_axi4_writer;
  localparam int BURST_LEN  = 16;
  localparam int FIFO_DEPTH = 32;
  localparam int AW         = 32;
  localparam int DW         = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy, done, error;
  logic [15:0]   beats_written;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;

  axi4_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

  axis_to_axi4_writer #(
    .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH), .AXI4_ADDR_W(AW), .AXI4_DATA_W(DW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .error(error), .beats_written(beats_written),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready), .axi(axi)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_aw [$];
  logic [63:0] exp_w [$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] stream_addr = '0;
  logic [63:0] e_aw, e_w;
  logic [39:0] aw_first = '0;
  logic [31:0] cur_addr = '0;
  int          aw_delay = 0, b_delay = 0, b_err_idx = -1;
  int          b_count = 0, resp_idx = 0, b_wait = 0, aw_cnt = 0, beats_left = 0;
  bit          w_toggle = 1'b0, in_burst = 1'b0, b_pending = 1'b0, b_taken = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] mkAw(input logic [31:0] a, input logic [7:0] l);
    return {24'h0, a, l};
  endfunction

  // RAM slave: drives ready/response at the falling edge, then samples the handshakes that the next rising edge will complete.
  always @(negedge clk) begin
    if (!reset_n) begin
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.bvalid  = 1'b0;
      axi.bresp   = 2'b00;
      in_burst    = 1'b0;
      b_pending   = 1'b0;
      b_taken     = 1'b0;
      aw_cnt      = 0;
      exp_w.delete();
      exp_aw.delete();
    end else begin
      if (b_taken) begin
        axi.bvalid = 1'b0;
        b_taken    = 1'b0;
      end
      if (b_pending) begin
        if (b_wait > 0) b_wait--;
        else begin
          axi.bvalid = 1'b1;
          axi.bresp  = (resp_idx == b_err_idx) ? 2'b10 : 2'b00;
          resp_idx++;
          b_pending = 1'b0;
        end
      end
      if (axi.awvalid) begin
        if (aw_cnt == 0) aw_first = {axi.awaddr, axi.awlen};
        axi.awready = (aw_cnt >= aw_delay);
        aw_cnt++;
      end else begin
        axi.awready = 1'b0;
      end
      axi.wready = w_toggle ? !axi.wready : 1'b1;
      #1;
      if (s_axis_tvalid && s_axis_tready) begin
        exp_w.push_back({stream_addr, s_axis_tdata});
        stream_addr += 4;
      end
      if (axi.wvalid && axi.wready) begin
        if (!in_burst) checkOutput("w_before_aw", axi.wvalid, 0);
        else begin
          if (exp_w.size() == 0) checkOutput("w_extra", axi.wvalid, 0);
          else begin
            e_w = exp_w.pop_front();
            checkOutput("waddr", cur_addr, e_w[63:32]);
            checkOutput("wdata", axi.wdata, e_w[31:0]);
          end
          checkOutput("wlast", axi.wlast, beats_left == 1);
          checkOutput("wstrb", axi.wstrb, 4'hF);
          mem[cur_addr] = axi.wdata;
          cur_addr += 4;
          beats_left--;
          if (beats_left == 0) begin
            in_burst  = 1'b0;
            b_pending = 1'b1;
            b_wait    = b_delay;
          end
        end
      end
      if (axi.awvalid && axi.awready) begin
        if (aw_cnt > 1) checkOutput("aw_hold", {axi.awaddr, axi.awlen}, aw_first);
        aw_cnt = 0;
        checkOutput("awsize", axi.awsize, 3'b010);
        checkOutput("awburst", axi.awburst, 2'b01);
        if (exp_aw.size() == 0) checkOutput("aw_unexpected", axi.awvalid, 0);
        else begin
          e_aw = exp_aw.pop_front();
          checkOutput("awaddr", axi.awaddr, e_aw[39:8]);
          checkOutput("awlen", axi.awlen, e_aw[7:0]);
        end
        in_burst   = 1'b1;
        cur_addr   = axi.awaddr;
        beats_left = int'(axi.awlen) + 1;
      end
      if (axi.bvalid && axi.bready) begin
        b_count++;
        b_taken = 1'b1;
      end
    end
  end

  task automatic issueStart(input logic [31:0] base);
    stream_addr = {base[31:2], 2'b00};
    b_count     = 0;
    resp_idx    = 0;
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("tready_after_start", s_axis_tready, 1);
    checkOutput("err_cleared", error, 0);
    checkOutput("bw_cleared", beats_written, 0);
  endtask

  task automatic sendBeats(input int n, input bit gap, input bit counting);
    int cyc;
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        s_axis_tvalid = 1'b0;
        @(negedge clk);
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = counting ? 32'(i) : $urandom;
      s_axis_tlast  = (i == n - 1);
      cyc = 0;
      #1;
      while (!s_axis_tready && cyc < 1000) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      if (cyc >= 1000) checkOutput("tready_timeout", s_axis_tready, 1);
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] base, input int n, input bit gap,
                               input bit counting, input int bursts, input bit exp_err);
    int cyc;
    issueStart(base);
    sendBeats(n, gap, counting);
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("done", done, 1);
    checkOutput("busy_at_done", busy, 1);
    checkOutput("error", error, exp_err);
    checkOutput("beats_written", beats_written, n);
    checkOutput("b_count", b_count, bursts);
    checkOutput("aw_left", exp_aw.size(), 0);
    checkOutput("w_left", exp_w.size(), 0);
    @(negedge clk);
    checkOutput("done_pulse", done, 0);
    checkOutput("busy_idle", busy, 0);
  endtask

  initial begin
    int cyc;
    axi.arready = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b0;
    axi.rvalid  = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    checkOutput("reset_state", {busy, done, error, s_axis_tready, axi.awvalid, axi.wvalid, axi.bready}, 0);
    checkOutput("reset_bw", beats_written, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] single 16-beat burst at 0x100");
    exp_aw.push_back(mkAw(32'h100, 8'd15));
    applyStimulus(32'h100, 16, 1'b0, 1'b1, 1, 1'b0);
    for (int i = 0; i < 16; i++) checkOutput("ram", mem[32'h100 + 32'(4 * i)], 64'(i));

    $display("[TB] 20 beats split by BURST_LEN");
    exp_aw.push_back(mkAw(32'h0, 8'd15));
    exp_aw.push_back(mkAw(32'h40, 8'd3));
    applyStimulus(32'h0, 20, 1'b0, 1'b0, 2, 1'b0);

    $display("[TB] 8 beats near a 4 KB boundary");
`ifdef AXIS_WR_4K_SPLIT_EN
    exp_aw.push_back(mkAw(32'hFF8, 8'd1));
    exp_aw.push_back(mkAw(32'h1000, 8'd5));
    applyStimulus(32'hFF8, 8, 1'b0, 1'b0, 2, 1'b0);
`else
    exp_aw.push_back(mkAw(32'hFF8, 8'd7));
    applyStimulus(32'hFF8, 8, 1'b0, 1'b0, 1, 1'b0);
`endif

    $display("[TB] gappy stream, slow AW, toggling wready, delayed B");
    w_toggle = 1'b1;
    b_delay  = 3;
    aw_delay = 2;
    exp_aw.push_back(mkAw(32'h2000, 8'd15));
    exp_aw.push_back(mkAw(32'h2040, 8'd7));
    applyStimulus(32'h2000, 24, 1'b1, 1'b0, 2, 1'b0);
    w_toggle = 1'b0;
    b_delay  = 0;
    aw_delay = 0;

    $display("[TB] SLVERR on second burst, unaligned base");
    b_err_idx = 1;
    exp_aw.push_back(mkAw(32'h3000, 8'd15));
    exp_aw.push_back(mkAw(32'h3040, 8'd3));
    applyStimulus(32'h3002, 20, 1'b0, 1'b0, 2, 1'b1);
    b_err_idx = -1;

    $display("[TB] reset during DATA, then a clean frame");
    exp_aw.push_back(mkAw(32'h4000, 8'd15));
    issueStart(32'h4000);
    sendBeats(16, 1'b0, 1'b0);
    cyc = 0;
    while (!axi.wvalid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("wvalid_seen", axi.wvalid, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_outputs", {busy, done, error, s_axis_tready, axi.awvalid, axi.wvalid, axi.bready}, 0);
    checkOutput("rst_bw", beats_written, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    exp_aw.push_back(mkAw(32'h5000, 8'd9));
    applyStimulus(32'h5000, 10, 1'b0, 1'b0, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
